// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control sequencer for the datapath.
// Drives PC/fetch, latches flags, resolves branches, parks in HALT.
module cpu_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic [3:0]  FLG,
  output logic [7:0]  PC,
  output logic        fetch,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      st;
  state_t      bnd;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic [3:0]  op;
  logic        is_alu;
  logic        is_ldst;
  logic        is_br;
  logic        is_halt;
  logic        take;

  assign op      = ir[27:24];
  assign is_alu  = ~op[3];
  assign is_ldst = (op == 4'h8) || (op == 4'h9);
  assign is_br   = (op == 4'hA);
  assign is_halt = (op == 4'hF);
  assign bnd     = run ? S_FETCH : S_IDLE;

  assign state  = st;
  assign fetch  = (st == S_FETCH);
  assign halted = (st == S_HALT);

  // flags layout: [3]=N [2]=Z [1]=C [0]=V
  always_comb begin
    take = 1'b0;
    case (ir[31:28])
      4'h0: take = flags[2];
      4'h1: take = ~flags[2];
      4'h2: take = flags[1];
      4'h3: take = ~flags[1];
      4'h4: take = flags[3];
      4'h5: take = ~flags[3];
      4'h6: take = flags[0];
      4'h7: take = ~flags[0];
      4'hE: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= S_IDLE;
      PC      <= PC_RESET;
      ir      <= '0;
      flags   <= '0;
      retired <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (run) st <= S_FETCH;
        end
        S_FETCH: begin
          ir <= instr;
          st <= S_DECODE;
        end
        S_DECODE: begin
          unique case (1'b1)
            is_alu, is_ldst: begin
              st <= S_EXEC;
            end
            is_br: begin
              PC      <= take ? ir[7:0] : PC + 8'd1;
              retired <= retired + 16'd1;
              st      <= bnd;
            end
            is_halt: begin
              retired <= retired + 16'd1;
              st      <= S_HALT;
            end
            default: begin
              PC      <= PC + 8'd1;
              retired <= retired + 16'd1;
              st      <= bnd;
            end
          endcase
        end
        S_EXEC: begin
          if (is_alu) begin
            flags   <= FLG;
            PC      <= PC + 8'd1;
            retired <= retired + 16'd1;
            st      <= bnd;
          end else begin
            st <= S_MEM;
          end
        end
        S_MEM: begin
          PC      <= PC + 8'd1;
          retired <= retired + 16'd1;
          st      <= bnd;
        end
        S_HALT: begin
          st <= S_HALT;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Table-driven bench for cpu_sequencer with an expected-result queue.
// Each instruction is fed at its FETCH cycle and scored at its boundary.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] instr;
  logic [3:0]  FLG;
  logic [7:0]  PC;
  logic        fetch;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] retired;

  cpu_sequencer #(.PC_RESET(8'h10)) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .instr(instr),
    .FLG(FLG),
    .PC(PC),
    .fetch(fetch),
    .halted(halted),
    .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  flg;
    logic [7:0]  pc;
    logic [15:0] ret;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ret;
    int          cyc;
  } exp_t;

  vec_t v[18];
  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic wait_fetch(output bit ok);
    int n = 0;
    while (!fetch && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = fetch;
  endtask

  initial begin
    bit          ok;
    int          c;
    bit          stable;
    logic [7:0]  start;
    logic [7:0]  pc_exp;
    exp_t        e;
    int          nf;

    v[0]  = '{32'h0100_0000, 4'b0000, 8'h11, 16'd1,  3};
    v[1]  = '{32'h0100_0000, 4'b0000, 8'h12, 16'd2,  3};
    v[2]  = '{32'h0100_0000, 4'b0100, 8'h13, 16'd3,  3};
    v[3]  = '{32'h0A00_0040, 4'b0000, 8'h40, 16'd4,  2};
    v[4]  = '{32'h0100_0000, 4'b0000, 8'h41, 16'd5,  3};
    v[5]  = '{32'h0A00_0080, 4'b0000, 8'h42, 16'd6,  2};
    v[6]  = '{32'h0800_0000, 4'b1111, 8'h43, 16'd7,  4};
    v[7]  = '{32'h0900_0000, 4'b1111, 8'h44, 16'd8,  4};
    v[8]  = '{32'h1A00_0060, 4'b1111, 8'h60, 16'd9,  2};
    v[9]  = '{32'h0B00_0000, 4'b0000, 8'h61, 16'd10, 2};
    v[10] = '{32'hEA00_00FF, 4'b0000, 8'hFF, 16'd11, 2};
    v[11] = '{32'h0100_0000, 4'b0010, 8'h00, 16'd12, 3};
    v[12] = '{32'h2A00_0020, 4'b0000, 8'h20, 16'd13, 2};
    v[13] = '{32'hFA00_0077, 4'b0000, 8'h21, 16'd14, 2};
    v[14] = '{32'h4A00_0030, 4'b0000, 8'h22, 16'd15, 2};
    v[15] = '{32'h0100_0000, 4'b1001, 8'h23, 16'd16, 3};
    v[16] = '{32'h6A00_0005, 4'b0000, 8'h05, 16'd17, 2};
    v[17] = '{32'h0F00_0000, 4'b0000, 8'h05, 16'd18, 2};

    reset = 1'b1;
    run   = 1'b0;
    instr = '0;
    FLG   = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_pc", PC, 8'h10);
    chk("rst_retired", retired, 16'd0);
    chk("rst_fetch", fetch, 1'b0);
    chk("rst_halted", halted, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", state, 3'd0);
    run = 1'b1;
    @(negedge clk);
    chk("idle_to_fetch", fetch, 1'b1);

    pc_exp = 8'h10;
    for (int i = 0; i < 18; i++) begin
      wait_fetch(ok);
      chk("fetch_seen", ok, 1'b1);
      chk("pc_at_fetch", PC, pc_exp);
      instr = v[i].ins;
      FLG   = v[i].flg;
      sb.push_back('{v[i].pc, v[i].ret, v[i].cyc});
      c      = 1;
      stable = 1'b1;
      start  = PC;
      forever begin
        @(negedge clk);
        if (fetch || halted || state == 3'd0 || c > 10) break;
        if (PC !== start) stable = 1'b0;
        c++;
      end
      e = sb.pop_front();
      chk("pc_next", PC, e.pc);
      chk("retired", retired, e.ret);
      chk("cycles", c, e.cyc);
      chk("pc_stable", stable, 1'b1);
      pc_exp = e.pc;
    end

    chk("halted", halted, 1'b1);
    nf = 0;
    repeat (20) begin
      @(negedge clk);
      if (fetch) nf++;
    end
    chk("halt_no_fetch", nf, 0);
    chk("halt_pc", PC, 8'h05);
    chk("halt_sticky", halted, 1'b1);
    chk("halt_state", state, 3'd5);

    reset = 1'b1;
    @(negedge clk);
    chk("halt_exit_rst", halted, 1'b0);
    reset = 1'b0;
    wait_fetch(ok);
    chk("ldr_fetch", ok, 1'b1);
    instr = 32'h0800_0000;
    repeat (3) @(negedge clk);
    chk("in_mem", state, 3'd4);
    run = 1'b0;
    @(negedge clk);
    chk("drop_idle", state, 3'd0);
    chk("drop_retired", retired, 16'd1);
    chk("drop_pc", PC, 8'h11);
    repeat (3) @(negedge clk);
    chk("idle_stay", state, 3'd0);
    chk("idle_nofetch", fetch, 1'b0);
    run = 1'b1;
    @(negedge clk);
    chk("rerun_fetch", fetch, 1'b1);
    chk("rerun_pc", PC, 8'h11);
    instr = 32'h0100_0000;
    repeat (2) @(negedge clk);
    chk("in_exec", state, 3'd3);
    #1 reset = 1'b1;
    #1;
    chk("async_state", state, 3'd0);
    chk("async_pc", PC, 8'h10);
    chk("async_retired", retired, 16'd0);
    chk("async_fetch", fetch, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
